// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port byte RAM between the instruction-fetch
// port and the load/store data port. One transaction in flight at a time;
// data has priority, with a streak counter that bounds fetch starvation.
module mem_arbiter #(
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_access,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // RAM side
  output logic        ram_load,
  output logic        ram_store,
  output logic [2:0]  ram_access,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  localparam int unsigned SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(STREAK_MAX);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [1:0] ERR   = 2'd3;

  // port id encoding for port_q
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  logic [1:0]    state_q,  state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          port_q,   port_d;
  logic          we_q,     we_d;
  logic [2:0]    access_q, access_d;
  logic [31:0]   addr_q,   addr_d;
  logic [31:0]   wdata_q,  wdata_d;

  logic idle;
  logic fetch_sel;
  logic data_sel;
  logic i_legal;
  logic d_legal;

  // Access code and natural-alignment check applied at grant time.
  function automatic logic access_legal(input logic we, input logic [2:0] acc,
                                        input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (acc)
      3'b000:  ok = 1'b1;
      3'b001:  ok = (a[0] == 1'b0);
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = !we;
      3'b101:  ok = !we && (a[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Arbitration: data wins unless it has already won STREAK_MAX times in a
  // row while fetch was waiting.
  always_comb begin
    idle      = (state_q == IDLE);
    fetch_sel = i_req && (!d_req || (streak_q == STREAK_TOP));
    data_sel  = d_req && !fetch_sel;
    i_gnt     = idle && fetch_sel;
    d_gnt     = idle && data_sel;
    i_legal   = (i_addr[1:0] == 2'b00);
    d_legal   = access_legal(d_we, d_access, d_addr[1:0]);
  end

  // Next-state, request latch and streak update.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    port_d   = port_q;
    we_d     = we_q;
    access_d = access_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (i_gnt) begin
          port_d   = PORT_FETCH;
          we_d     = 1'b0;
          access_d = 3'b010;
          addr_d   = i_addr;
          wdata_d  = '0;
          streak_d = '0;
          state_d  = i_legal ? ISSUE : ERR;
        end else if (d_gnt) begin
          port_d   = PORT_DATA;
          we_d     = d_we;
          access_d = d_access;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          if (!i_req)
            streak_d = '0;
          else if (streak_q != STREAK_TOP)
            streak_d = streak_q + SW'(1);
          state_d  = d_legal ? ISSUE : ERR;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      streak_q <= '0;
      port_q   <= PORT_FETCH;
      we_q     <= 1'b0;
      access_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      port_q   <= port_d;
      we_q     <= we_d;
      access_q <= access_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Outputs decoded from the state register so reset clears them at once.
  always_comb begin
    busy       = (state_q != IDLE);
    ram_load   = (state_q == ISSUE) && !we_q;
    ram_store  = (state_q == ISSUE) && we_q;
    ram_access = (state_q == ISSUE) ? access_q : '0;
    ram_addr   = (state_q == ISSUE) ? addr_q   : '0;
    ram_wdata  = (state_q == ISSUE) ? wdata_q  : '0;

    i_rvalid = ((state_q == RESP) || (state_q == ERR)) && (port_q == PORT_FETCH);
    i_err    = (state_q == ERR) && (port_q == PORT_FETCH);
    i_rdata  = ((state_q == RESP) && (port_q == PORT_FETCH)) ? ram_rdata : '0;

    d_rvalid = ((state_q == RESP) || (state_q == ERR)) && (port_q == PORT_DATA);
    d_err    = (state_q == ERR) && (port_q == PORT_DATA);
    d_rdata  = ((state_q == RESP) && (port_q == PORT_DATA) && !we_q) ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand-written sequences for
// starvation and mid-transaction reset. A small byte RAM model sits behind
// the arbiter and does the load formatting.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [2:0]  d_access;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        ram_load, ram_store;
  logic [2:0]  ram_access;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned nload  = 0;
  int unsigned nstore = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STREAK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_access(d_access), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_err(d_err),
    .ram_load(ram_load), .ram_store(ram_store), .ram_access(ram_access),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy)
  );

  // Byte RAM model, little-endian, registered read with load formatting.
  logic [7:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    ram_rdata = '0;
  end

  always @(posedge clk) begin
    logic [7:0] a;
    a = ram_addr[7:0];
    if (ram_store) begin
      mem[a] <= ram_wdata[7:0];
      if (ram_access == 3'b001 || ram_access == 3'b010) mem[a + 8'd1] <= ram_wdata[15:8];
      if (ram_access == 3'b010) begin
        mem[a + 8'd2] <= ram_wdata[23:16];
        mem[a + 8'd3] <= ram_wdata[31:24];
      end
    end
    if (ram_load) begin
      case (ram_access)
        3'b000:  ram_rdata <= {{24{mem[a][7]}}, mem[a]};
        3'b001:  ram_rdata <= {{16{mem[a + 8'd1][7]}}, mem[a + 8'd1], mem[a]};
        3'b100:  ram_rdata <= {24'h0, mem[a]};
        3'b101:  ram_rdata <= {16'h0, mem[a + 8'd1], mem[a]};
        default: ram_rdata <= {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
      endcase
    end
  end

  // Strobe pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_load)  nload++;
    if (ram_store) nstore++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    string       name;
    logic        fetch;
    logic        we;
    logic [2:0]  acc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  // Issue one request, follow it through grant, strobe and response.
  task automatic run_vec(input vec_t v);
    int unsigned n;
    logic g;
    @(negedge clk);
    if (v.fetch) begin
      i_req = 1'b1; i_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_access = v.acc; d_addr = v.addr; d_wdata = v.wdata;
    end
    #1;
    n = 0;
    g = v.fetch ? i_gnt : d_gnt;
    while (!g && n < 20) begin
      @(negedge clk); #1;
      n++;
      g = v.fetch ? i_gnt : d_gnt;
    end
    chk({v.name, " gnt"}, {31'b0, g}, 32'd1);
    chk({v.name, " gnt_wait"}, n, 32'd0);
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    if (!v.exp_err) begin
      chk({v.name, " load_strobe"}, {31'b0, ram_load}, {31'b0, !v.we});
      chk({v.name, " store_strobe"}, {31'b0, ram_store}, {31'b0, v.we});
      chk({v.name, " ram_addr"}, ram_addr, v.addr);
      chk({v.name, " ram_access"}, {29'b0, ram_access}, {29'b0, v.acc});
      chk({v.name, " early_rvalid"}, {30'b0, i_rvalid, d_rvalid}, 32'd0);
      @(negedge clk);
    end
    chk({v.name, " strobes_in_resp"}, {30'b0, ram_load, ram_store}, 32'd0);
    chk({v.name, " rvalid"}, {30'b0, i_rvalid, d_rvalid}, v.fetch ? 32'd2 : 32'd1);
    chk({v.name, " err"}, {31'b0, v.fetch ? i_err : d_err}, {31'b0, v.exp_err});
    chk({v.name, " rdata"}, v.fetch ? i_rdata : d_rdata, v.exp_rdata);
  endtask

  localparam int NV = 13;
  vec_t vt [NV];

  initial begin
    int unsigned exp_loads, exp_stores, n, ng;
    string pat, exp_pat;

    vt[0]  = '{"sw_10",   1'b0, 1'b1, 3'b010, 32'h10, 32'h12345678, 1'b0, 32'h0};
    vt[1]  = '{"fetch_10",1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h12345678};
    vt[2]  = '{"sb_3",    1'b0, 1'b1, 3'b000, 32'h3,  32'hAAAA5580, 1'b0, 32'h0};
    vt[3]  = '{"lb_3",    1'b0, 1'b0, 3'b000, 32'h3,  32'h0,        1'b0, 32'hFFFFFF80};
    vt[4]  = '{"lbu_3",   1'b0, 1'b0, 3'b100, 32'h3,  32'h0,        1'b0, 32'h00000080};
    vt[5]  = '{"sh_6",    1'b0, 1'b1, 3'b001, 32'h6,  32'h1234BEEF, 1'b0, 32'h0};
    vt[6]  = '{"lhu_6",   1'b0, 1'b0, 3'b101, 32'h6,  32'h0,        1'b0, 32'h0000BEEF};
    vt[7]  = '{"lh_6",    1'b0, 1'b0, 3'b001, 32'h6,  32'h0,        1'b0, 32'hFFFFBEEF};
    vt[8]  = '{"lh_5",    1'b0, 1'b0, 3'b001, 32'h5,  32'h0,        1'b1, 32'h0};
    vt[9]  = '{"sw_6",    1'b0, 1'b1, 3'b010, 32'h6,  32'hDEADBEEF, 1'b1, 32'h0};
    vt[10] = '{"fetch_2", 1'b1, 1'b0, 3'b010, 32'h2,  32'h0,        1'b1, 32'h0};
    vt[11] = '{"st_acc4", 1'b0, 1'b1, 3'b100, 32'h0,  32'hFFFFFFFF, 1'b1, 32'h0};
    vt[12] = '{"lw_10",   1'b0, 1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h12345678};

    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_access = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_strobes", {30'b0, ram_load, ram_store}, 32'd0);
    chk("reset_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
    chk("reset_streak", {29'b0, dut.streak_q}, 32'd0);
    rst_n = 1'b1;

    exp_loads = 0; exp_stores = 0;
    for (int k = 0; k < NV; k++) begin
      if (!vt[k].exp_err) begin
        if (vt[k].we) exp_stores++; else exp_loads++;
      end
      run_vec(vt[k]);
    end
    @(negedge clk);
    chk("total_loads", nload, exp_loads);
    chk("total_stores", nstore, exp_stores);

    // Starvation: both ports held; expect D,D,D,D,I repeating.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_access = 3'b010; d_addr = 32'h0;
    pat = ""; exp_pat = "DDDDIDDDDI";
    n = 0; ng = 0;
    while (ng < 10 && n < 100) begin
      #1;
      if (i_gnt) begin
        pat = {pat, "I"}; ng++;
        @(negedge clk);
        chk("streak_after_fetch", {29'b0, dut.streak_q}, 32'd0);
      end else begin
        if (d_gnt) begin pat = {pat, "D"}; ng++; end
        @(negedge clk);
      end
      n++;
    end
    checks++;
    if (pat != exp_pat) begin
      errors++;
      $display("FAIL grant_pattern: got %s expected %s", pat, exp_pat);
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during ISSUE of a store.
    d_req = 1'b1; d_we = 1'b1; d_access = 3'b010; d_addr = 32'h20; d_wdata = 32'hCAFEF00D;
    #1;
    chk("rst_seq gnt", {31'b0, d_gnt}, 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    chk("rst_seq store_before", {31'b0, ram_store}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_seq store_dropped", {31'b0, ram_store}, 32'd0);
    chk("rst_seq busy", {31'b0, busy}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_seq no_rvalid", {31'b0, d_rvalid}, 32'd0);
    end
    rst_n = 1'b1;
    run_vec('{"after_rst_lw", 1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h12345678});

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-port byte RAM. It shares that RAM between the instruction-fetch port and the load/store data port. Each accepted request is checked for a legal access code and natural alignment, then driven onto the RAM's load/store strobes for exactly one cycle. The registered read result is returned with a one-cycle valid pulse. Data requests have priority, and a streak counter bounds fetch starvation.

## Interface
- STREAK_MAX, 4: max consecutive data grants while fetch waits (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request, held until i_gnt
- i_addr  in  32  fetch byte address (always word access 3'b010)
- i_gnt  out  1  fetch accepted this cycle (combinational, IDLE only)
- i_rvalid  out  1  fetch response pulse
- i_rdata  out  32  fetch word, valid with i_rvalid
- i_err  out  1  misaligned fetch, valid with i_rvalid
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 store, 0 load
- d_access  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  data response pulse (load and store)
- d_rdata  out  32  load result; 0 for stores/errors
- d_err  out  1  illegal/misaligned, valid with d_rvalid
- ram_load, ram_store  out  1  RAM strobes, one cycle each
- ram_access  out  3  to RAM access
- ram_addr, ram_wdata  out  32  to RAM addr/data_in
- ram_rdata  in  32  from RAM data_out (registered in RAM)
- busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, ISSUE, RESP, ERR. At most one transaction is in flight.
- IDLE arbitration:
  - If only one port requests, grant it.
  - If both request, grant data unless streak == STREAK_MAX; in that case grant fetch.
- On a grant, latch port id, we, access, addr and wdata into the request registers. Fetch latches access=010 and we=0.
- Legality check at grant:
  - Loads may use 000/001/010/100/101.
  - Stores may use 000/001/010.
  - Halfword needs addr[0]=0. Word needs addr[1:0]=00.
  - Fetch needs i_addr[1:0]=00.
- Grant transitions:
  - Legal grant → ISSUE.
  - Illegal grant → ERR. No RAM strobe is ever issued for an illegal request.
- ISSUE: drive ram_load=!we or ram_store=we from the latched registers, for exactly one cycle. Go to RESP.
- RESP: assert the selected port's rvalid for one cycle.
  - Loads: rdata=ram_rdata.
  - Stores: rdata=0.
  - err=0. Go to IDLE.
- ERR: assert rvalid and err for one cycle with rdata=0. Go to IDLE.
- Streak counter, width $clog2(STREAK_MAX+1):
  - Data grant while i_req=1 → +1, saturating.
  - Data grant while i_req=0 → 0.
  - Fetch grant → 0.
- Outputs outside their strobe cycles:
  - ram_* outputs are 0 except in ISSUE.
  - rvalid/err/rdata are 0 except in RESP/ERR.
- The requester owns the held request. Arbitration in IDLE ignores changes to request fields before the grant.

## Timing
- Legal request: gnt in cycle T, RAM strobe in T+1, rvalid/rdata in T+2. The next grant is possible in T+3.
- Illegal request: gnt in T, rvalid+err in T+1. The next grant is possible in T+2.
- gnt is asserted only in IDLE with busy=0. A request arriving while busy waits, with no grant.
- Reset (async, any state): FSM → IDLE, streak → 0, request registers → 0, all outputs 0.
  - An in-flight transaction is dropped with no rvalid.
  - If reset lands during ISSUE, the strobe is removed immediately. RAM contents are not this block's responsibility.
- Simultaneous requests at STREAK_MAX: fetch wins and streak clears in the same edge.

## Test plan
- Fetch LW at 0x10 after a data SW 0x12345678 to 0x10: d_rvalid at T+2. Fetch gnt at T+3, i_rdata=0x12345678 at T+5, ram_load high only in T+4.
- Data LB from 0x3 holding 0x80 → d_rdata=0xFFFFFF80. LBU from 0x3 → 0x00000080. Each is a single ram_load pulse.
- Misaligned cases, each with rvalid one cycle after gnt and no ram_load/ram_store pulse ever:
  - LH at 0x5 → d_err=1, d_rdata=0.
  - SW at 0x6 → d_err=1.
  - Fetch at 0x2 → i_err=1.
  - Store with access 100 → d_err=1.
- Starvation with STREAK_MAX=4, i_req and d_req both held continuously: grant pattern D,D,D,D,I repeating. Streak reads 0 after each fetch grant.
- Assert rst_n=0 in the ISSUE cycle of a store: ram_store drops asynchronously, no d_rvalid, busy=0. After release, a new d_req is granted in the first cycle.
